sp_ram_march_bist: RTL

// Initiator-side March C- BIST engine driving the single-port SRAM wrapper port
// (en/addr/we/be/wdata -> rdata, 1-cycle read latency). Sits between the memory
// and its normal bus master; the top-level mux hands it the port while busy_o=1.

---
 rtl/sp_ram_march_bist.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sp_ram_march_bist.sv
// March C- built-in self test engine for a single-port SRAM with 1-cycle read latency.
// Drives one request per cycle and checks each readback on the following cycle.
module sp_ram_march_bist #(
  parameter int                    RAM_SIZE   = 32768,
  parameter int                    ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 32'h5555_5555
) (
  input  logic                      clk,
  input  logic                      rstn_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      fail_o,
  output logic [ADDR_WIDTH-1:0]     fail_addr_o,
  output logic [DATA_WIDTH-1:0]     fail_data_o,
  output logic                      mem_en_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      mem_bypass_en_o
);

  localparam int BE_W       = DATA_WIDTH / 8;
  localparam int NUM_WORDS  = RAM_SIZE / BE_W;
  localparam int IDX_W      = $clog2(NUM_WORDS) + 1;
  localparam int BYTE_SHIFT = $clog2(BE_W);

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] D0       = PATTERN;
  localparam logic [DATA_WIDTH-1:0] D1       = ~PATTERN;

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] idx);
    return ADDR_WIDTH'(idx) << BYTE_SHIFT;
  endfunction

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    phase_q, phase_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic                    fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d;

  logic                    el_rd, el_wr, el_down, next_down;
  logic [DATA_WIDTH-1:0]   el_rval, el_wval;
  state_t                  el_next;
  logic                    in_elem, busy, is_read, step, at_last, mismatch;

  // Per-element operation table: which ops, which backgrounds, which direction.
  always_comb begin
    el_rd     = 1'b0;
    el_wr     = 1'b0;
    el_down   = 1'b0;
    el_rval   = D0;
    el_wval   = D0;
    el_next   = S_FLUSH;
    next_down = 1'b0;
    unique case (state_q)
      S_M0: begin el_wr = 1'b1; el_wval = D0; el_next = S_M1; end
      S_M1: begin el_rd = 1'b1; el_rval = D0; el_wr = 1'b1; el_wval = D1; el_next = S_M2; end
      S_M2: begin
        el_rd = 1'b1; el_rval = D1; el_wr = 1'b1; el_wval = D0;
        el_next = S_M3; next_down = 1'b1;
      end
      S_M3: begin
        el_rd = 1'b1; el_rval = D0; el_wr = 1'b1; el_wval = D1; el_down = 1'b1;
        el_next = S_M4; next_down = 1'b1;
      end
      S_M4: begin
        el_rd = 1'b1; el_rval = D1; el_wr = 1'b1; el_wval = D0; el_down = 1'b1;
        el_next = S_M5;
      end
      S_M5: begin el_rd = 1'b1; el_rval = D0; el_next = S_FLUSH; end
      default: ;
    endcase
  end

  assign in_elem  = state_q inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
  assign busy     = in_elem || (state_q == S_FLUSH);
  assign is_read  = el_rd && (!el_wr || !phase_q);
  assign step     = !(el_rd && el_wr) || phase_q;
  assign at_last  = el_down ? (idx_q == '0) : (idx_q == LAST_IDX);
  // Readback from the previous cycle's read request is checked here.
  assign mismatch = busy && rd_pend_q && (mem_rdata_i != exp_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    rd_pend_d   = 1'b0;
    exp_d       = exp_q;
    raddr_d     = raddr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;

    if (in_elem) begin
      mem_en_o   = 1'b1;
      mem_be_o   = '1;
      mem_addr_o = word_addr(idx_q);
      if (is_read) begin
        rd_pend_d = 1'b1;
        exp_d     = el_rval;
        raddr_d   = word_addr(idx_q);
      end else begin
        mem_we_o    = 1'b1;
        mem_wdata_o = el_wval;
      end
      if (step) begin
        phase_d = 1'b0;
        if (at_last) begin
          state_d = el_next;
          idx_d   = next_down ? LAST_IDX : '0;
        end else begin
          idx_d = el_down ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
        end
      end else begin
        phase_d = 1'b1;
      end
    end else if (state_q == S_FLUSH) begin
      state_d = S_DONE;
    end else if (start_i) begin
      state_d     = S_M0;
      idx_d       = '0;
      phase_d     = 1'b0;
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_data_d = '0;
    end

    // First mismatch wins; the request already on the port this cycle still goes out.
    if (mismatch) begin
      state_d     = S_DONE;
      rd_pend_d   = 1'b0;
      fail_d      = 1'b1;
      fail_addr_d = raddr_q;
      fail_data_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      rd_pend_q   <= rd_pend_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  // Expected-data stage: only meaningful while rd_pend_q is set.
  always_ff @(posedge clk) begin
    exp_q   <= exp_d;
    raddr_q <= raddr_d;
  end

  assign busy_o          = busy;
  assign done_o          = (state_q == S_DONE);
  assign fail_o          = fail_q;
  assign fail_addr_o     = fail_addr_q;
  assign fail_data_o     = fail_data_q;
  assign mem_bypass_en_o = 1'b0;

endmodule
